// File: rtl/sonar_pkg.sv
// Shared scale constants, state encoding and distance clamp for both ends of the sonar link.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package sonar_pkg;

  localparam int DEF_CYCLES_PER_INCH   = 14_700;
  localparam int DEF_TRIG_MIN_CYCLES   = 2_000;
  localparam int DEF_ECHO_DELAY_CYCLES = 25_000;
  localparam int DEF_HOLDOFF_CYCLES    = 1_000_000;
  localparam int DEF_MIN_IN            = 6;
  localparam int DEF_MAX_IN            = 254;
  localparam int DEF_REFRESH_CYCLES    = 4_900_000;

  localparam int DIST_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLDOFF = 3'd4
  } sonar_state_e;

  // Limit a requested range to what the emulated sensor can report.
  function automatic logic [DIST_W-1:0] clamp_dist(input logic [DIST_W-1:0] d,
                                                   input int lo, input int hi);
    int v;
    v = {{(32-DIST_W){1'b0}}, d};
    if (v < lo) v = lo;
    else if (v > hi) v = hi;
    return v[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/sonar_inch_ticker.sv
// Prescaler 0..CYCLES_PER_INCH-1; tick is high on the last count of each inch.
// Latency: tick is combinational from the count; clear takes effect next cycle.
// Backpressure: none; counts only while en is high.
module sonar_inch_ticker import sonar_pkg::*; #(
  parameter int CYCLES_PER_INCH = DEF_CYCLES_PER_INCH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CYCLES_PER_INCH > 1) ? $clog2(CYCLES_PER_INCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_INCH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sonar_emulator.sv
// Ultrasonic rangefinder emulator: qualified trigger -> echo delay -> PWM of dist*CPI clocks.
// Latency: trigger pin fall to PWM rise = 3 + ECHO_DELAY_CYCLES clocks; free-run via SONAR_EMU_FREERUN_EN.
// Backpressure: none; triggers arriving while busy are dropped.
module sonar_emulator import sonar_pkg::*; #(
  parameter int CYCLES_PER_INCH   = DEF_CYCLES_PER_INCH,
  parameter int TRIG_MIN_CYCLES   = DEF_TRIG_MIN_CYCLES,
  parameter int ECHO_DELAY_CYCLES = DEF_ECHO_DELAY_CYCLES,
  parameter int HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES,
  parameter int MIN_IN            = DEF_MIN_IN,
  parameter int MAX_IN            = DEF_MAX_IN,
  parameter int REFRESH_CYCLES    = DEF_REFRESH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sonar_trigger,
  input  logic [DIST_W-1:0] distance_set,
  output logic              sonar_pwm,
  output logic              busy,
  output logic              pulse_done
);

  localparam int HI_W    = $clog2(TRIG_MIN_CYCLES + 1);
  localparam int TMR_MAX = (ECHO_DELAY_CYCLES > HOLDOFF_CYCLES) ? ECHO_DELAY_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [HI_W-1:0]  HI_MIN    = HI_W'(TRIG_MIN_CYCLES);
  localparam logic [TMR_W-1:0] ECHO_LAST = TMR_W'(ECHO_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);

  sonar_state_e      state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              trig_s_q, trig_s_d;
  logic              trig_d1_q, trig_d1_d;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DIST_W-1:0] inch_q, inch_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              pwm_q, pwm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trig_rise, trig_fall;
  logic              inch_tick;
  logic              start_auto;
  logic              arm_rd;

  assign trig_rise = trig_s_q & ~trig_d1_q;
  assign trig_fall = ~trig_s_q & trig_d1_q;

`ifdef SONAR_EMU_FREERUN_EN
  // per_cnt measures time since the trigger went high or since the last PWM rise,
  // so a held trigger paces readings at REFRESH_CYCLES rise-to-rise.
  localparam int PER_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(REFRESH_CYCLES);
  localparam logic [PER_W-1:0] AUTO_AT = PER_W'(REFRESH_CYCLES - ECHO_DELAY_CYCLES - 1);

  logic [PER_W-1:0] per_cnt_q, per_cnt_d;

  assign start_auto = ((state_q == ST_IDLE) || (state_q == ST_ARMED)) && trig_s_q &&
                      (per_cnt_q >= AUTO_AT);
`else
  // The refresh period only matters to the free-run build.
  logic unused_refresh;
  assign unused_refresh = (REFRESH_CYCLES != 0);
  assign start_auto     = 1'b0;
`endif

  sonar_inch_ticker #(
    .CYCLES_PER_INCH(CYCLES_PER_INCH)
  ) u_ticker (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_PULSE),
    .en   (state_q == ST_PULSE),
    .tick (inch_tick)
  );

  // Next-state logic for trigger qualification, echo delay, pulse timing and hold-off.
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    tmr_d     = tmr_q;
    inch_d    = inch_q;
    dist_d    = dist_q;
    pwm_d     = pwm_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    arm_rd    = 1'b0;
    sync1_d   = sonar_trigger;
    trig_s_d  = sync1_q;
    trig_d1_d = trig_s_q;
`ifdef SONAR_EMU_FREERUN_EN
    if (!trig_s_q)                per_cnt_d = '0;
    else if (per_cnt_q != PER_MAX) per_cnt_d = per_cnt_q + PER_W'(1);
    else                          per_cnt_d = per_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        hi_cnt_d = '0;
        if (start_auto) begin
          arm_rd = 1'b1;
        end else if (trig_rise) begin
          state_d  = ST_ARMED;
          hi_cnt_d = HI_W'(1);
        end
      end
      ST_ARMED: begin
        if (start_auto) begin
          arm_rd = 1'b1;
        end else if (trig_s_q) begin
          if (hi_cnt_q != HI_MIN) hi_cnt_d = hi_cnt_q + HI_W'(1);
        end else if (trig_fall && (hi_cnt_q >= HI_MIN)) begin
          arm_rd = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (tmr_q == ECHO_LAST) begin
          state_d = ST_PULSE;
          pwm_d   = 1'b1;
          inch_d  = '0;
          tmr_d   = '0;
`ifdef SONAR_EMU_FREERUN_EN
          per_cnt_d = '0;
`endif
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_PULSE: begin
        if (inch_tick) begin
          if (inch_q == dist_q - DIST_W'(1)) begin
            state_d = ST_HOLDOFF;
            pwm_d   = 1'b0;
            done_d  = 1'b1;
            tmr_d   = '0;
          end else begin
            inch_d = inch_q + DIST_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pwm_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // Starting a reading samples the requested range exactly once.
    if (arm_rd) begin
      state_d  = ST_DELAY;
      dist_d   = clamp_dist(distance_set, MIN_IN, MAX_IN);
      tmr_d    = '0;
      busy_d   = 1'b1;
      hi_cnt_d = '0;
    end
  end

  // State, synchroniser and registered-output flops; reset kills any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      trig_s_q  <= 1'b0;
      trig_d1_q <= 1'b0;
      hi_cnt_q  <= '0;
      tmr_q     <= '0;
      inch_q    <= '0;
      dist_q    <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SONAR_EMU_FREERUN_EN
      per_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      trig_s_q  <= trig_s_d;
      trig_d1_q <= trig_d1_d;
      hi_cnt_q  <= hi_cnt_d;
      tmr_q     <= tmr_d;
      inch_q    <= inch_d;
      dist_q    <= dist_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SONAR_EMU_FREERUN_EN
      per_cnt_q <= per_cnt_d;
`endif
    end
  end

  assign sonar_pwm  = pwm_q;
  assign busy       = busy_q;
  assign pulse_done = done_q;

endmodule

// File: tb/tb_sonar_emulator.sv
// Bench for sonar_emulator: event-time model of readings plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sonar_emulator;

  localparam int CPI  = 10;
  localparam int TMIN = 20;
  localparam int ECHO = 5;
  localparam int HOLD = 50;
  localparam int MINI = 6;
  localparam int MAXI = 254;
  localparam int REFR = 400;
  localparam int NCYC = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sonar_trigger = 1'b0;
  logic [8:0] distance_set = 9'd0;
  logic       sonar_pwm, busy, pulse_done;

  sonar_emulator #(
    .CYCLES_PER_INCH  (CPI),
    .TRIG_MIN_CYCLES  (TMIN),
    .ECHO_DELAY_CYCLES(ECHO),
    .HOLDOFF_CYCLES   (HOLD),
    .MIN_IN           (MINI),
    .MAX_IN           (MAXI),
    .REFRESH_CYCLES   (REFR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sonar_trigger(sonar_trigger),
    .distance_set (distance_set),
    .sonar_pwm    (sonar_pwm),
    .busy         (busy),
    .pulse_done   (pulse_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus history, indexed by the clock edge after which the value was driven.
  bit pin_h [NCYC];
  int dset_h[NCYC];
  bit rst_h [NCYC];

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle numbers of the scheduled reading (-1 = none).
  int m_rise = -1, m_fall = -1, m_bstart = -1, m_bend = -1;
  bit m_armed = 1'b0;
  int m_arm_start = 0;
  int m_hs = -1;

  // Observed pulses.
  bit pwm_prev = 1'b0;
  int last_rise = -1, last_width = -1, npulses = 0, ndone = 0;
  int rises[$];

  function automatic int clampd(input int d);
    if (d < MINI) return MINI;
    if (d > MAXI) return MAXI;
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sched(input int c);
    m_bstart = c + 1;
    m_rise   = c + 1 + ECHO;
    m_fall   = m_rise + clampd(dset_h[c]) * CPI;
    m_bend   = m_fall + HOLD;
  endtask

  // Model update and output comparison, once per cycle away from the active edge.
  always @(negedge clk) begin : model_cmp
    int c;
    bit ts, tsp, idle, start, e_pwm, e_busy, e_done;
`ifdef SONAR_EMU_FREERUN_EN
    int anchor;
`endif
    c = cyc;
    if (c >= 1 && c < NCYC) begin
      pin_h[c]  = sonar_trigger;
      dset_h[c] = int'(distance_set);
      rst_h[c]  = rst;
      if (c <= 1 || rst_h[c-1]) begin
        m_rise = -1; m_fall = -1; m_bstart = -1; m_bend = -1;
        m_armed = 1'b0; m_hs = -1;
      end else begin
        ts  = (c >= 2) ? pin_h[c-2] : 1'b0;
        tsp = (c >= 3) ? pin_h[c-3] : 1'b0;
        if (!ts) m_hs = -1;
        else if (m_hs < 0) m_hs = c;
        idle  = !m_armed && (m_bend < 0 || c >= m_bend);
        start = 1'b0;
`ifdef SONAR_EMU_FREERUN_EN
        anchor = (m_rise >= 0 && m_rise <= c && m_hs >= 0 && m_rise >= m_hs) ? m_rise : m_hs;
        if (ts && (idle || m_armed) && c >= anchor + REFR - ECHO - 1) start = 1'b1;
`endif
        if (start) begin
          m_armed = 1'b0;
          sched(c);
        end else if (idle && ts && !tsp) begin
          m_armed = 1'b1;
          m_arm_start = c;
        end else if (m_armed && !ts) begin
          m_armed = 1'b0;
          if (c - m_arm_start >= TMIN) sched(c);
        end
      end
      e_pwm  = (m_rise >= 0) && (c >= m_rise) && (c < m_fall);
      e_done = (m_fall >= 0) && (c == m_fall);
      e_busy = (m_bstart >= 0) && (c >= m_bstart) && (c < m_bend);
      checks++;
      if ({sonar_pwm, busy, pulse_done} !== {e_pwm, e_busy, e_done}) begin
        errors++;
        $display("FAIL cycle %0d pwm/busy/done: got %b%b%b expected %b%b%b",
                 c, sonar_pwm, busy, pulse_done, e_pwm, e_busy, e_done);
      end
      if (sonar_pwm && !pwm_prev) begin
        last_rise = c;
        rises.push_back(c);
      end
      if (!sonar_pwm && pwm_prev) begin
        last_width = c - last_rise;
        npulses++;
      end
      if (pulse_done) ndone++;
      pwm_prev = sonar_pwm;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trig(input int w, output int fall_n);
    sonar_trigger = 1'b1;
    tick(w);
    sonar_trigger = 1'b0;
    fall_n = cyc;
  endtask

  initial begin
    int f, x, np0, nd0;
`ifdef SONAR_EMU_FREERUN_EN
    int s, k0;
`endif
    rst = 1'b1;
    tick(3);
    chk("reset_pwm", int'(sonar_pwm), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(pulse_done), 0);
    rst = 1'b0;
    tick(2);

    // Basic reading: 25-clk trigger, 12 inches.
    distance_set = 9'd12;
    np0 = npulses; nd0 = ndone; last_width = -1;
    trig(25, f);
    tick(2);
    chk("t1_busy_before_delay", int'(busy), 0);
    tick(1);
    chk("t1_busy_in_delay", int'(busy), 1);
    tick(200);
    chk("t1_rise_latency", last_rise - f, 8);
    chk("t1_width", last_width, 120);
    chk("t1_pulses", npulses - np0, 1);
    chk("t1_done_count", ndone - nd0, 1);

    // Short trigger: no reading.
    np0 = npulses;
    trig(10, f);
    tick(5);
    chk("short_busy", int'(busy), 0);
    tick(60);
    chk("short_no_pulse", npulses - np0, 0);

    // Width boundary: 19 rejected, 20 accepted.
    trig(19, f);
    tick(60);
    chk("w19_no_pulse", npulses - np0, 0);
    last_width = -1;
    trig(20, f);
    tick(200);
    chk("w20_pulse", npulses - np0, 1);
    chk("w20_width", last_width, 120);

    // Clamping.
    distance_set = 9'd0; last_width = -1;
    trig(25, f);
    tick(150);
    chk("clamp_min_width", last_width, 60);
    distance_set = 9'd400; last_width = -1;
    trig(25, f);
    tick(2700);
    chk("clamp_max_width", last_width, 2540);

    // Retrigger in PULSE, distance change mid-pulse, trigger spanning HOLDOFF exit.
    distance_set = 9'd12; np0 = npulses; last_width = -1;
    trig(25, f);
    tick(20);
    distance_set = 9'd7;
    trig(25, x);
    tick(95);
    trig(60, x);
    tick(30);
    chk("retrig_width", last_width, 120);
    chk("retrig_pulses", npulses - np0, 1);
    last_width = -1;
    trig(25, f);
    tick(150);
    chk("next_dist_width", last_width, 70);
    chk("next_dist_pulses", npulses - np0, 2);

    // Reset mid-PULSE.
    distance_set = 9'd12; nd0 = ndone;
    trig(25, f);
    tick(40);
    rst = 1'b1;
    tick(1);
    chk("rst_pwm_low", int'(sonar_pwm), 0);
    chk("rst_busy_low", int'(busy), 0);
    rst = 1'b0;
    tick(150);
    chk("rst_no_done", ndone - nd0, 0);
    last_width = -1;
    trig(25, f);
    tick(200);
    chk("post_rst_width", last_width, 120);
    chk("post_rst_done", ndone - nd0, 1);

`ifdef SONAR_EMU_FREERUN_EN
    // Free-run: held trigger paces readings every REFR clocks.
    np0 = npulses; k0 = rises.size();
    sonar_trigger = 1'b1;
    s = cyc;
    tick(1300);
    sonar_trigger = 1'b0;
    tick(900);
    chk("fr_pulses", npulses - np0, 3);
    if (rises.size() >= k0 + 3) begin
      chk("fr_first_rise", rises[k0] - s, 402);
      chk("fr_period1", rises[k0+1] - rises[k0], 400);
      chk("fr_period2", rises[k0+2] - rises[k0+1], 400);
    end else begin
      chk("fr_rise_count", rises.size() - k0, 3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
